rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_pkg.sv | 17 +
 rtl/rf_write_arbiter_rr_arb2.sv | 34 +++
 rtl/rf_write_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds the FSM state encoding and the register-file geometry.
package rf_write_arbiter_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; grant doubles as the combinational ready.
// last_grant remembers the most recently served requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = '0;
    if (en) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  // A grant is only ever raised alongside its valid, so any grant is a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port,
// optionally zero-filling every register after reset before accepting writes.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic              init_done
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] clear_cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] wa_nxt;
  logic [DATA_W-1:0] wd_nxt;
  logic              arb_en;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Readies must read low throughout reset, even when resetting straight into RUN.
  assign arb_en = (state == ST_RUN) && !rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;

  always_comb begin
    next_state = state;
    cnt_nxt    = clear_cnt;
    we_nxt     = 1'b0;
    wa_nxt     = WA;
    wd_nxt     = WD;
    unique case (state)
      ST_CLEAR: begin
        we_nxt = 1'b1;
        wa_nxt = clear_cnt;
        wd_nxt = '0;
        if (clear_cnt == LAST_REG) begin
          next_state = ST_RUN;
        end else begin
          cnt_nxt = clear_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (|grant) begin
          we_nxt = (sel_addr != ZERO_REG);
          wa_nxt = sel_addr;
          wd_nxt = sel_data;
        end
      end
      default: next_state = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clear_cnt <= '0;
      RegWrite  <= 1'b0;
      WA        <= '0;
      WD        <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= next_state;
      clear_cnt <= cnt_nxt;
      RegWrite  <= we_nxt;
      WA        <= wa_nxt;
      WD        <= wd_nxt;
      init_done <= (next_state == ST_RUN);
    end
  end

endmodule
